sram_responder: RTL and testbench
=================================

# sram_responder

Memory-side responder for the LC-3 datapath's active-low SRAM strobe interface (Mem_CE/OE/WE/UB/LB), replacing the physical SRAM in simulation and on-chip builds. It decodes the strobes driven by the instruction sequencing control unit, serves reads after a parameterised latency, commits byte-masked writes into an internal word array, and flags when read data is valid. It sits between the MAR/MDR datapath and the memory array.

## Interface
Parameters:
- ADDR_W, 10: word-address width; array depth is 2**ADDR_W 16-bit words.
- READ_LAT, 1: cycles from first sampled read request to valid data. Legal range is 1..4.

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high.
- Mem_CE  in  1  chip enable, active-low.
- Mem_OE  in  1  output enable (read strobe), active-low.
- Mem_WE  in  1  write enable, active-low.
- Mem_UB  in  1  upper byte lane [15:8] enable, active-low.
- Mem_LB  in  1  lower byte lane [7:0] enable, active-low.
- ADDR  in  ADDR_W  word address, driven from MAR.
- Data_in  in  16  write data, driven from MDR.
- Data_out  out  16  read data returned to the MDR input mux.
- Data_valid  out  1  Data_out holds the word for the current read request.
- Busy  out  1  a read is in progress but its data is not yet valid.

## Operation
- Request decode: a write is `!Mem_CE & !Mem_WE`. A read is `!Mem_CE & !Mem_OE & Mem_WE`. If both WE and OE are low, the write wins and no read occurs. Mem_CE high means idle, whatever the other strobes are.
- States are IDLE, READ_WAIT, READ_HOLD and WRITE.
- IDLE:
  - Write sampled: go to WRITE and commit at the same edge.
  - Read sampled: capture ADDR and load cnt = READ_LAT-1. If cnt is 0, load Data_out and go to READ_HOLD; otherwise go to READ_WAIT.
- READ_WAIT:
  - Request still a read at the same address: decrement cnt. When cnt reaches 1, the next edge loads Data_out and moves to READ_HOLD.
  - Address changes: restart the count with the new address.
  - Request drops or becomes a write: abandon the read and go to IDLE or WRITE.
- READ_HOLD:
  - Data_valid = 1 while the read at the captured address persists.
  - Address changes: treat as a new read (restart as from IDLE).
  - Request drops: go to IDLE.
  - Write sampled: go to WRITE.
- WRITE:
  - Every edge with a write sampled writes Data_in lanes into array[ADDR]. UB low enables [15:8]; LB low enables [7:0].
  - Holding WE low for several cycles rewrites the same data, which is harmless.
  - WE released: go to IDLE, or straight into a read if OE is low.
- Read byte lanes: a disabled lane returns 8'h00 in Data_out.
- Address width: ADDR is used as-is. The 16-bit MAR is truncated to ADDR_W bits upstream, so addresses wrap modulo the array depth.

## Timing
- Reset values: Data_out = 16'h0000, Data_valid = 0, Busy = 0, state = IDLE, cnt = 0.
- Reset does not clear the array. A reset asserted mid-read or mid-write aborts the access at that edge. A write sampled at the same edge as Reset is not committed.
- Read latency:
  - If the request is first sampled at edge E0, Data_out and Data_valid update at edge E0+READ_LAT-1.
  - With READ_LAT = 1, data is valid in the cycle after OE first goes low. This matches a two-cycle OE-low read whose MDR load happens in the second cycle.
- Busy: 1 in READ_WAIT; 0 in all other states.
- Data_valid deasserts at the first edge where the read request is no longer sampled. Data_out keeps its last value.
- Write latency: committed at the sampling edge. A read of the same address that starts on the next cycle returns the new data (write-through ordering).
- All outputs are registered; none depend combinationally on inputs.

## Structure
- Shared package lc3_mem_pkg holds:
  - the state enum typedef;
  - WORD_W = 16;
  - the localparam request codes (REQ_NONE, REQ_READ, REQ_WRITE).
- Sub-module sram_array:
  - 2**ADDR_W × 16 storage;
  - per-byte write enables;
  - synchronous write and synchronous read port.
- sram_responder holds the FSM, the latency counter, the captured address and the output registers.

## Test plan
- Reset: hold Reset high for 2 cycles with random strobes -> Data_out = 16'h0000, Data_valid = 0, Busy = 0.
- Full write then read (READ_LAT = 1):
  - Stimulus: CE=0, WE=0, UB=LB=0, ADDR=10'h005, Data_in=16'h1234 for 2 cycles; then OE=0, WE=1 at 10'h005.
  - Required: Data_valid = 1 and Data_out = 16'h1234 one cycle after OE falls.
- Byte lanes:
  - Stimulus: write 16'hABCD to 10'h010 with only UB low, after a prior 16'h0000 write; then read with both lanes enabled, then read with only LB enabled.
  - Required: first read returns 16'hAB00; second read returns 16'h0000.
- Strobe priority: OE=0 and WE=0 together with Data_in=16'h5A5A at 10'h020 -> write commits, Data_valid stays 0, and a later read returns 16'h5A5A.
- READ_LAT = 3, with 16'h1111 at 10'h001 and 16'h2222 at 10'h002:
  - Read 10'h001 -> Busy = 1 for 2 cycles, then Data_valid = 1 with 16'h1111.
  - ADDR changed to 10'h002 while in READ_WAIT -> count restarts; 16'h2222 is valid 3 edges after the change.
- Reset during READ_WAIT -> IDLE next edge with Data_valid = 0; a subsequent read still returns the preserved 16'h1111.

Source files
------------

// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC-3 SRAM responder: FSM states, word width
// and the decoded strobe request codes.
package lc3_mem_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ_WAIT,
    ST_READ_HOLD,
    ST_WRITE
  } state_e;

  localparam logic [1:0] REQ_NONE  = 2'd0;
  localparam logic [1:0] REQ_READ  = 2'd1;
  localparam logic [1:0] REQ_WRITE = 2'd2;

  // Active-low strobes; a write wins over a simultaneous read.
  function automatic logic [1:0] decode_req(input logic ce_n, input logic oe_n, input logic we_n);
    logic [1:0] req;
    req = REQ_NONE;
    if (!ce_n && !we_n) begin
      req = REQ_WRITE;
    end else if (!ce_n && !oe_n) begin
      req = REQ_READ;
    end
    return req;
  endfunction

endpackage

// File: rtl/sram_array.sv
// 2**ADDR_W x 16 word storage with per-byte write enables, a synchronous write port
// and a registered (synchronous) read port. Contents are never reset.
module sram_array
  import lc3_mem_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              i_clk,
  input  logic              i_wr_en,
  input  logic [1:0]        i_wr_be,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [WORD_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [WORD_W-1:0] o_rd_data
);

  logic [WORD_W-1:0] r_mem [2**ADDR_W];
  logic [WORD_W-1:0] r_rd_data;

  always_ff @(posedge i_clk) begin
    if (i_wr_en && i_wr_be[1]) begin
      r_mem[i_wr_addr][WORD_W-1:8] <= i_wr_data[WORD_W-1:8];
    end
    if (i_wr_en && i_wr_be[0]) begin
      r_mem[i_wr_addr][7:0] <= i_wr_data[7:0];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/sram_responder.sv
// Memory-side responder for the LC-3 active-low SRAM strobe interface: decodes
// CE/OE/WE/UB/LB, serves reads after READ_LAT cycles and commits byte-masked writes.
module sram_responder
  import lc3_mem_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int READ_LAT = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Mem_CE,
  input  logic              Mem_OE,
  input  logic              Mem_WE,
  input  logic              Mem_UB,
  input  logic              Mem_LB,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [WORD_W-1:0] Data_in,
  output logic [WORD_W-1:0] Data_out,
  output logic              Data_valid,
  output logic              Busy
);

  localparam logic [2:0] CNT_INIT = 3'(READ_LAT - 1);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [2:0]        r_cnt;
  logic [2:0]        w_cnt_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [1:0]        r_lane;
  logic              r_valid;
  logic              r_busy;
  logic [1:0]        w_req;
  logic              w_same;
  logic              w_load;
  logic              w_wr;
  logic [WORD_W-1:0] w_rd_word;

  assign w_req  = decode_req(Mem_CE, Mem_OE, Mem_WE);
  assign w_same = (ADDR == r_addr);

  always_comb begin
    w_state_nxt = ST_IDLE;
    w_cnt_nxt   = 3'd0;
    w_addr_nxt  = r_addr;
    w_load      = 1'b0;
    w_wr        = 1'b0;
    case (w_req)
      REQ_WRITE: begin
        w_state_nxt = ST_WRITE;
        w_wr        = 1'b1;
      end
      REQ_READ: begin
        if (r_state == ST_READ_WAIT && w_same) begin
          if (r_cnt <= 3'd1) begin
            w_load      = 1'b1;
            w_state_nxt = ST_READ_HOLD;
          end else begin
            w_cnt_nxt   = r_cnt - 3'd1;
            w_state_nxt = ST_READ_WAIT;
          end
        end else if (r_state == ST_READ_HOLD && w_same) begin
          w_state_nxt = ST_READ_HOLD;
        end else begin
          // Fresh read: from IDLE/WRITE, or an address change mid-read.
          w_addr_nxt = ADDR;
          if (CNT_INIT == 3'd0) begin
            w_load      = 1'b1;
            w_state_nxt = ST_READ_HOLD;
          end else begin
            w_cnt_nxt   = CNT_INIT;
            w_state_nxt = ST_READ_WAIT;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 3'd0;
      r_lane  <= 2'b00;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_valid <= (w_state_nxt == ST_READ_HOLD);
      r_busy  <= (w_state_nxt == ST_READ_WAIT);
      if (w_load) begin
        r_lane <= {~Mem_UB, ~Mem_LB};
      end
    end
  end

  always_ff @(posedge Clk) begin
    r_addr <= w_addr_nxt;
  end

  // Reset gates both ports so an access sampled with Reset is dropped.
  sram_array #(
    .ADDR_W(ADDR_W)
  ) u_array (
    .i_clk     (Clk),
    .i_wr_en   (w_wr & ~Reset),
    .i_wr_be   ({~Mem_UB, ~Mem_LB}),
    .i_wr_addr (ADDR),
    .i_wr_data (Data_in),
    .i_rd_en   (w_load & ~Reset),
    .i_rd_addr (ADDR),
    .o_rd_data (w_rd_word)
  );

  // Lane mask is registered with the read word; cleared on reset so Data_out reads zero.
  assign Data_out   = {w_rd_word[WORD_W-1:8] & {8{r_lane[1]}}, w_rd_word[7:0] & {8{r_lane[0]}}};
  assign Data_valid = r_valid;
  assign Busy       = r_busy;

endmodule

// File: tb/tb_sram_responder.sv
// Scoreboard bench for sram_responder: two instances (READ_LAT 1 and 3) share one
// strobe stream; a request-run reference model predicts valid data and Busy.
module tb_sram_responder;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        CE, OE, WE, UB, LB;
  logic [9:0]  ADDR;
  logic [15:0] DIN;
  logic [15:0] dout1, dout3;
  logic        dv1, dv3, busy1, busy3;

  always #5 Clk = ~Clk;

  sram_responder #(.ADDR_W(10), .READ_LAT(1)) dut1 (
    .Clk(Clk), .Reset(Reset), .Mem_CE(CE), .Mem_OE(OE), .Mem_WE(WE),
    .Mem_UB(UB), .Mem_LB(LB), .ADDR(ADDR), .Data_in(DIN),
    .Data_out(dout1), .Data_valid(dv1), .Busy(busy1)
  );

  sram_responder #(.ADDR_W(10), .READ_LAT(3)) dut3 (
    .Clk(Clk), .Reset(Reset), .Mem_CE(CE), .Mem_OE(OE), .Mem_WE(WE),
    .Mem_UB(UB), .Mem_LB(LB), .ADDR(ADDR), .Data_in(DIN),
    .Data_out(dout3), .Data_valid(dv3), .Busy(busy3)
  );

  typedef struct {
    int          cyc;
    logic [15:0] data;
  } exp_t;

  exp_t        q1[$];
  exp_t        q3[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          mon_en = 0;
  logic [15:0] ref_mem [1024];
  int          run [2];
  logic [9:0]  run_addr [2];
  logic [15:0] last [2];
  bit          busy_exp [2];

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic push(input int k, input logic [15:0] d);
    exp_t e;
    e.cyc  = cyc;
    e.data = d;
    if (k == 0) q1.push_back(e);
    else        q3.push_back(e);
  endtask

  // A read request is a run of consecutive sampled reads at one address; data
  // appears on the READ_LAT-th edge of the run and stays valid until the run ends.
  task automatic model_edge();
    bit wr, rd;
    wr = !CE && !WE;
    rd = !CE && !OE && WE;
    busy_exp[0] = 0;
    busy_exp[1] = 0;
    if (Reset) begin
      run[0] = 0;
      run[1] = 0;
    end else if (wr) begin
      if (!UB) ref_mem[ADDR][15:8] = DIN[15:8];
      if (!LB) ref_mem[ADDR][7:0]  = DIN[7:0];
      run[0] = 0;
      run[1] = 0;
    end else if (rd) begin
      for (int k = 0; k < 2; k++) begin
        if (run[k] > 0 && run_addr[k] == ADDR) begin
          if (run[k] <= lat_of(k)) run[k] = run[k] + 1;
        end else begin
          run[k]      = 1;
          run_addr[k] = ADDR;
        end
        if (run[k] == lat_of(k))
          last[k] = {UB ? 8'h00 : ref_mem[ADDR][15:8], LB ? 8'h00 : ref_mem[ADDR][7:0]};
        if (run[k] >= lat_of(k)) push(k, last[k]);
        else                     busy_exp[k] = 1;
      end
    end else begin
      run[0] = 0;
      run[1] = 0;
    end
  endtask

  task automatic step();
    @(posedge Clk);
    cyc++;
    model_edge();
    #1;
    if (mon_en) begin
      check("busy_lat1", 16'(busy1), 16'(busy_exp[0]));
      check("busy_lat3", 16'(busy3), 16'(busy_exp[1]));
    end
  endtask

  task automatic mon(input int k, input logic v, input logic [15:0] d);
    exp_t e;
    bit   have;
    have = 0;
    if (k == 0 && q1.size() > 0) begin have = 1; e = q1[0]; end
    if (k == 1 && q3.size() > 0) begin have = 1; e = q3[0]; end
    if (v) begin
      checks++;
      if (!have) begin
        errors++;
        $display("FAIL unexpected_valid lat%0d at cycle %0d: got valid 1 expected valid 0", lat_of(k), cyc);
      end else begin
        if (k == 0) void'(q1.pop_front());
        else        void'(q3.pop_front());
        if (e.cyc != cyc) begin
          errors++;
          $display("FAIL valid_timing lat%0d: got valid at cycle %0d expected cycle %0d", lat_of(k), cyc, e.cyc);
        end
        check($sformatf("read_data_lat%0d", lat_of(k)), d, e.data);
      end
    end else if (have && e.cyc <= cyc) begin
      checks++;
      errors++;
      $display("FAIL missed_valid lat%0d at cycle %0d: got valid 0 expected valid 1 with %h", lat_of(k), cyc, e.data);
      if (k == 0) void'(q1.pop_front());
      else        void'(q3.pop_front());
    end
  endtask

  always @(negedge Clk) begin
    if (mon_en) begin
      mon(0, dv1, dout1);
      mon(1, dv3, dout3);
    end
  end

  task automatic drive(input logic ce, input logic oe, input logic we, input logic ub,
                       input logic lb, input logic [9:0] a, input logic [15:0] d);
    CE = ce; OE = oe; WE = we; UB = ub; LB = lb; ADDR = a; DIN = d;
  endtask

  task automatic wr(input logic [9:0] a, input logic [15:0] d, input logic ub, input logic lb);
    drive(1'b0, 1'b1, 1'b0, ub, lb, a, d);
  endtask

  task automatic rd(input logic [9:0] a, input logic ub, input logic lb);
    drive(1'b0, 1'b0, 1'b1, ub, lb, a, DIN);
  endtask

  task automatic idle();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, ADDR, DIN);
  endtask

  initial begin
    run[0] = 0; run[1] = 0;
    Reset = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 10'h000, 16'h0000);
    for (int i = 0; i < 2; i++) begin
      {CE, OE, WE, UB, LB} = 5'($urandom);
      ADDR = 10'($urandom);
      DIN  = 16'($urandom);
      step();
    end
    mon_en = 1;
    check("reset_dout_lat1", dout1, 16'h0000);
    check("reset_dout_lat3", dout3, 16'h0000);
    check("reset_valid_lat1", 16'(dv1), 16'h0000);
    check("reset_valid_lat3", 16'(dv3), 16'h0000);
    check("reset_busy_lat3", 16'(busy3), 16'h0000);
    Reset = 1'b0;
    idle(); step();

    // Full write then read
    wr(10'h005, 16'h1234, 1'b0, 1'b0); step(); step();
    rd(10'h005, 1'b0, 1'b0); step();
    check("full_rd_valid", 16'(dv1), 16'h0001);
    check("full_rd_data", dout1, 16'h1234);
    idle(); step();

    // Byte lanes
    wr(10'h010, 16'h0000, 1'b0, 1'b0); step();
    wr(10'h010, 16'hABCD, 1'b0, 1'b1); step();
    rd(10'h010, 1'b0, 1'b0); step();
    check("lanes_both", dout1, 16'hAB00);
    idle(); step();
    rd(10'h010, 1'b1, 1'b0); step();
    check("lanes_lb_only", dout1, 16'h0000);
    idle(); step();

    // Strobe priority
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h020, 16'h5A5A); step();
    check("prio_no_valid", 16'(dv1), 16'h0000);
    idle(); step();
    rd(10'h020, 1'b0, 1'b0); step();
    check("prio_read", dout1, 16'h5A5A);
    idle(); step();

    // Latency 3 and address restart
    wr(10'h001, 16'h1111, 1'b0, 1'b0); step();
    wr(10'h002, 16'h2222, 1'b0, 1'b0); step();
    idle(); step();
    rd(10'h001, 1'b0, 1'b0); step();
    check("lat3_busy_e0", 16'(busy3), 16'h0001);
    step();
    check("lat3_busy_e1", 16'(busy3), 16'h0001);
    step();
    check("lat3_valid", 16'(dv3), 16'h0001);
    check("lat3_data", dout3, 16'h1111);
    check("lat3_busy_done", 16'(busy3), 16'h0000);
    idle(); step();
    rd(10'h001, 1'b0, 1'b0); step();
    rd(10'h002, 1'b0, 1'b0); step();
    step();
    check("restart_not_yet", 16'(dv3), 16'h0000);
    step();
    check("restart_valid", 16'(dv3), 16'h0001);
    check("restart_data", dout3, 16'h2222);
    idle(); step();

    // Reset during READ_WAIT; array contents survive
    rd(10'h001, 1'b0, 1'b0); step();
    Reset = 1'b1; step();
    check("rst_mid_valid", 16'(dv3), 16'h0000);
    check("rst_mid_busy", 16'(busy3), 16'h0000);
    Reset = 1'b0;
    step(); step(); step();
    check("rst_preserved_valid", 16'(dv3), 16'h0001);
    check("rst_preserved_data", dout3, 16'h1111);
    idle(); step();

    // Randomised traffic over a prefilled address window
    for (int a = 0; a < 8; a++) begin
      wr(10'(a), 16'($urandom), 1'b0, 1'b0); step();
    end
    for (int t = 0; t < 400; t++) begin
      int          len;
      int          kind;
      logic [9:0]  a;
      logic        ub, lb;
      len  = $urandom_range(1, 6);
      kind = $urandom_range(0, 9);
      a    = 10'($urandom_range(0, 7));
      ub   = ($urandom_range(0, 3) == 0);
      lb   = ($urandom_range(0, 3) == 0);
      for (int c = 0; c < len; c++) begin
        if (kind < 4)       rd(a, ub, lb);
        else if (kind < 6)  wr(a, 16'($urandom), ub, lb);
        else if (kind == 6) drive(1'b1, 1'($urandom), 1'($urandom), ub, lb, a, 16'($urandom));
        else if (kind == 7) drive(1'b0, 1'b0, 1'b0, ub, lb, a, 16'($urandom));
        else if (kind == 8) drive(1'b0, 1'b1, 1'b1, ub, lb, a, 16'($urandom));
        else                rd(10'($urandom_range(0, 7)), ub, lb);
        Reset = ($urandom_range(0, 149) == 0);
        step();
      end
    end
    Reset = 1'b0;
    idle(); step(); step();

    checks++;
    if (q1.size() != 0 || q3.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d/%0d pending expected 0/0", q1.size(), q3.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
